load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: bus cycles without mem_ack before a timeout fault.
REQ-002 SHALL use one clock; reset is synchronous and active-low; clock and reset ports are named clk and rst_n.
REQ-003 SHALL have ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- MemRead  in  1  load request from the control decoder.
- MemWrite  in  1  store request from the control decoder.
- LoadstoreSig  in  3  size code: 1=B, 2=H, 3=W, 4=BU, 5=HU.
- addr  in  32  byte address.
- wdata  in  32  store data; the low byte, half or word is used.
- stall  out  1  core must hold the current instruction.
- rdata  out  32  extended load result.
- done  out  1  one-cycle completion pulse.
- fault  out  1  one-cycle fault pulse.
- fault_cause  out  2  01=misaligned, 10=timeout, 11=illegal.
- mem_req  out  1  bus request.
- mem_we  out  1  1=write.
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  bus completion.
- mem_rdata  in  32  bus read word.

Function
REQ-004 SHALL implement the states IDLE, REQ, DONE and FAULT.
REQ-005 In IDLE with MemRead|MemWrite high, SHALL latch addr, wdata, size code and direction at the clock edge, and SHALL leave IDLE on that edge.
REQ-006 SHALL drive stall combinationally high in IDLE while MemRead|MemWrite is high, and in REQ; stall SHALL be low in DONE and FAULT.
REQ-007 SHALL treat the following as illegal (cause 11): MemRead&MemWrite both high, size code 0/6/7, or a store with code 4 or 5; an illegal request SHALL go IDLE->FAULT with no bus access.
REQ-008 SHALL treat a half access with addr[0]=1, or a word access with addr[1:0]!=0, as misaligned (cause 01); it SHALL go IDLE->FAULT with no bus access.
REQ-009 A legal request SHALL go IDLE->REQ; in REQ, mem_req=1 and mem_addr, mem_be, mem_we, mem_wdata SHALL be stable until mem_ack.
REQ-010 SHALL encode byte enables as follows: B/BU: 1<<addr[1:0]; H/HU: 0011 if addr[1]=0, else 1100; W: 1111; loads use the same mem_be pattern with mem_we=0.
REQ-011 SHALL build mem_wdata by replication: byte replicated to 4 lanes; half replicated to 2 lanes; word passed unchanged.
REQ-012 SHALL accept mem_ack in any REQ cycle, including the first; on ack, SHALL go to DONE and drop mem_req on the next edge.
REQ-013 On a load ack, SHALL select the lane from mem_rdata by addr[1:0], then extend it: LB and LH sign-extend; LBU and LHU zero-extend; LW passes through.
REQ-014 SHALL register the load result into rdata, valid from DONE and held until the next load completes; stores and faults SHALL leave rdata unchanged.
REQ-015 SHALL count each REQ cycle without ack in a wait counter; when the count reaches TIMEOUT_CYCLES, SHALL drop mem_req and go to FAULT with cause 10.
REQ-016 SHALL clear the wait counter on entry to REQ.
REQ-017 DONE SHALL last exactly 1 cycle with done=1, then go to IDLE; MemRead/MemWrite SHALL be ignored in DONE.
REQ-018 FAULT SHALL last exactly 1 cycle with fault=1 and fault_cause valid, then go to IDLE; fault_cause SHALL be 00 outside FAULT.
REQ-019 SHALL ignore mem_ack outside REQ.
REQ-020 Load latency with ack in the first REQ cycle SHALL be: request cycle, REQ, DONE = 3 cycles, with stall high for 2 of them.

Reset
REQ-021 When rst_n=0 at a clock edge, SHALL set state=IDLE, wait counter=0, rdata=0, and done, fault, fault_cause, mem_req, mem_we, mem_be, mem_addr, mem_wdata all to 0.
REQ-022 Reset during REQ SHALL drop mem_req on that edge; a late mem_ack arriving afterwards SHALL be ignored.
REQ-023 stall SHALL be 0 while rst_n=0.

Verification
REQ-024 SHALL cover this scenario: LB at addr 0x103 with mem_rdata 0x80FF_0000, ack on the first REQ cycle -> mem_be=1000, rdata=0xFFFF_FF80 in DONE, done pulse, stall high for 2 cycles.
REQ-025 SHALL cover this scenario: SH at 0x202 with wdata 0x0000_ABCD -> mem_addr=0x200, mem_be=1100, mem_wdata=0xABCD_ABCD, mem_we=1.
REQ-026 SHALL cover this scenario: LW at 0x006 -> fault=1 with cause 01 one cycle later, mem_req never asserted.
REQ-027 SHALL cover this scenario: LHU at 0x002, ack withheld -> mem_req high for 16 cycles, then fault with cause 10, then IDLE.
REQ-028 SHALL cover this scenario: MemRead=MemWrite=1, and separately a store with code 4 -> fault with cause 11, no bus access.
REQ-029 SHALL cover this scenario: rst_n=0 on the 3rd REQ cycle, then a late ack -> mem_req=0 after that edge, no done pulse, rdata=0.

Source files
------------

// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// load_store_unit
//
// Turns a MemRead/MemWrite request from the control decoder into a single
// bus transaction. The unit checks the request for illegal size codes and
// misalignment. It drives byte enables and lane-replicated store data, then
// waits for mem_ack or a timeout. A completed load is sign- or zero-extended
// into rdata.
//
// Ports
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   MemRead/MemWrite  load / store request (held by the core while stall=1)
//   LoadstoreSig      size code: 1=B, 2=H, 3=W, 4=BU, 5=HU
//   addr, wdata       byte address and store data
//   stall             core must hold the current instruction
//   rdata             extended load result, held until the next load
//   done, fault       one-cycle completion / fault pulses
//   fault_cause       01=misaligned, 10=timeout, 11=illegal (00 outside fault)
//   mem_*             single-beat word bus, mem_ack completes a transfer
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  LoadstoreSig,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        done,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] SZ_B  = 3'd1;
    localparam logic [2:0] SZ_H  = 3'd2;
    localparam logic [2:0] SZ_W  = 3'd3;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE,
        S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] wait_inc;
    logic [1:0]       cause_d;

    // Request attributes kept for the load-return path.
    logic [2:0]       size_q;
    logic [1:0]       addr_lo_q;

    // ---------------------------------------------------------------------
    // Request decode (valid only in IDLE, where the inputs are sampled)
    // ---------------------------------------------------------------------
    logic        req_any;
    logic        is_half;
    logic        is_word;
    logic        is_illegal;
    logic        is_misaligned;
    logic [3:0]  be_dec;
    logic [31:0] wdata_rep;

    assign req_any       = MemRead | MemWrite;
    assign is_half       = (LoadstoreSig == SZ_H) || (LoadstoreSig == SZ_HU);
    assign is_word       = (LoadstoreSig == SZ_W);
    // Unsigned sizes only make sense for loads, so a store with BU/HU is illegal.
    assign is_illegal    = (MemRead & MemWrite)
                         | (LoadstoreSig == 3'd0) | (LoadstoreSig > SZ_HU)
                         | (MemWrite & ((LoadstoreSig == SZ_BU) || (LoadstoreSig == SZ_HU)));
    assign is_misaligned = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        be_dec    = 4'b0000;
        wdata_rep = wdata;
        case (LoadstoreSig)
            SZ_B, SZ_BU: begin
                be_dec    = 4'b0001 << addr[1:0];
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_H, SZ_HU: begin
                be_dec    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            SZ_W: begin
                be_dec    = 4'b1111;
                wdata_rep = wdata;
            end
            default: begin
                be_dec    = 4'b0000;
                wdata_rep = wdata;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    assign wait_inc = wait_q + 1'b1;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        cause_d = CAUSE_NONE;
        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    if (is_illegal) begin
                        state_d = S_FAULT;
                        cause_d = CAUSE_ILLEGAL;
                    end else if (is_misaligned) begin
                        state_d = S_FAULT;
                        cause_d = CAUSE_MISALIGN;
                    end else begin
                        state_d = S_REQ;
                        wait_d  = '0;
                    end
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    state_d = S_DONE;
                end else if (wait_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d = S_FAULT;
                    cause_d = CAUSE_TIMEOUT;
                    wait_d  = wait_inc;
                end else begin
                    wait_d  = wait_inc;
                end
            end
            // Requests arriving in DONE/FAULT are ignored; the core is not
            // stalled there and re-presents them once the unit is back in IDLE.
            S_DONE:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Load return: pick the addressed lane, then extend
    // ---------------------------------------------------------------------
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;

    always_comb begin
        case (addr_lo_q)
            2'd0:    byte_lane = mem_rdata[7:0];
            2'd1:    byte_lane = mem_rdata[15:8];
            2'd2:    byte_lane = mem_rdata[23:16];
            default: byte_lane = mem_rdata[31:24];
        endcase
        half_lane = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (size_q)
            SZ_B:    load_ext = {{24{byte_lane[7]}}, byte_lane};
            SZ_BU:   load_ext = {24'd0, byte_lane};
            SZ_H:    load_ext = {{16{half_lane[15]}}, half_lane};
            SZ_HU:   load_ext = {16'd0, half_lane};
            default: load_ext = mem_rdata;
        endcase
    end

    // ---------------------------------------------------------------------
    // State and registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            size_q      <= 3'd0;
            addr_lo_q   <= 2'd0;
            rdata       <= 32'd0;
            done        <= 1'b0;
            fault       <= 1'b0;
            fault_cause <= CAUSE_NONE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_be      <= 4'b0000;
            mem_addr    <= 32'd0;
            mem_wdata   <= 32'd0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            done        <= (state_d == S_DONE);
            fault       <= (state_d == S_FAULT);
            fault_cause <= cause_d;
            // Dropped on ack or timeout; the other bus fields simply hold.
            mem_req     <= (state_d == S_REQ);

            // Capture the request as it leaves IDLE. Faulting requests are
            // captured too, but mem_req never rises so the bus never sees them.
            if (state_q == S_IDLE && req_any) begin
                size_q    <= LoadstoreSig;
                addr_lo_q <= addr[1:0];
                mem_we    <= MemWrite;
                mem_be    <= be_dec;
                mem_addr  <= {addr[31:2], 2'b00};
                mem_wdata <= wdata_rep;
            end

            if (state_q == S_REQ && mem_ack && !mem_we) begin
                rdata <= load_ext;
            end
        end
    end

    // Stall covers the request cycle and all of REQ; forced low in reset.
    assign stall = rst_n & (((state_q == S_IDLE) & req_any) | (state_q == S_REQ));

endmodule
